// File: rtl/lpif_pkg.sv
// Shared LPIF state codes, TX beat format and PHY FSM states for the
// PHY-side LPIF controller.
package lpif_pkg;

    localparam logic [3:0] ST_RESET     = 4'h0;
    localparam logic [3:0] ST_ACTIVE    = 4'h1;
    localparam logic [3:0] ST_L1        = 4'h4;
    localparam logic [3:0] ST_LINKRESET = 4'h9;
    localparam logic [3:0] ST_RETRAIN   = 4'hB;

    localparam logic [2:0] PROTO_PCIE = 3'b000;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  valid;
        logic [8:0]  tlp_start;
        logic [8:0]  tlp_end;
        logic [8:0]  dllp_start;
        logic [8:0]  dllp_end;
    } lpif_beat_t;

    typedef enum logic [2:0] {
        S_RESET,
        S_ACTIVE,
        S_RETRAIN,
        S_STALL,
        S_L1,
        S_LINKRESET
    } phy_state_e;

    // Width codes are log2(lanes); a code wider than the link is built for
    // is reported as the full link width.
    function automatic logic [2:0] clamp_width(input logic [2:0] code,
                                               input logic [2:0] max_code);
        return (code > max_code) ? max_code : code;
    endfunction

endpackage

// File: rtl/lpif_tx_fifo.sv
// First-word fall-through beat buffer between the LPIF boundary and the PHY
// TX path; flush drops all buffered beats in one cycle.
module lpif_tx_fifo
    import lpif_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  lpif_beat_t wr_beat,
    input  logic       pop,
    output lpif_beat_t rd_beat,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    // NOTE: storage is not reset; count and pointers alone decide which
    // entries are valid, so clearing the array would only cost area.
    lpif_beat_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);
    assign rd_beat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_beat;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/lpif_phy_ctrl.sv
// PHY-side LPIF controller: state_req/state_sts handshake, stall and
// clock-gate handshakes, and Irdy/trdy-controlled TX beat buffering.
module lpif_phy_ctrl
    import lpif_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LANES      = 16
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic [63:0] Data,
    input  logic [7:0]  Valid,
    input  logic        Irdy,
    input  logic [8:0]  tlp_start,
    input  logic [8:0]  tlp_end,
    input  logic [8:0]  dllp_start,
    input  logic [8:0]  dllp_end,
    input  logic [3:0]  state_req,
    input  logic        stall_ack,
    input  logic        ex_cg_ack,
    input  logic        ltssm_l0,
    input  logic        ltssm_recovery,
    input  logic [2:0]  lane_width,
    output logic        trdy,
    output logic [3:0]  state_sts,
    output logic        link_up,
    output logic [2:0]  link_cfg,
    output logic        stall_req,
    output logic        ex_cg_req,
    output logic        phyinl1,
    output logic        phyinrecenter,
    output logic        rxframe_errmask,
    output logic        protocol_valid,
    output logic [2:0]  protocol,
    output logic [63:0] tx_data,
    output logic [7:0]  tx_valid,
    output logic [8:0]  tx_tlp_start,
    output logic [8:0]  tx_tlp_end,
    output logic [8:0]  tx_dllp_start,
    output logic [8:0]  tx_dllp_end,
    output logic        tx_vld,
    input  logic        tx_rdy
);

    localparam logic [2:0] MAX_WIDTH_CODE = 3'($clog2(LANES));

    phy_state_e state;
    lpif_beat_t wr_beat;
    lpif_beat_t head_beat;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_flush;

    assign wr_beat = '{data: Data, valid: Valid, tlp_start: tlp_start,
                       tlp_end: tlp_end, dllp_start: dllp_start, dllp_end: dllp_end};
    assign fifo_flush = (state_req == ST_LINKRESET);

    assign trdy = (state == S_ACTIVE) && !stall_req && (!fifo_full || (tx_vld && tx_rdy));

    lpif_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (Clk),
        .reset   (reset),
        .flush   (fifo_flush),
        .push    (Irdy && trdy),
        .wr_beat (wr_beat),
        .pop     (tx_rdy),
        .rd_beat (head_beat),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign tx_vld         = !fifo_empty;
    assign tx_data        = head_beat.data;
    assign tx_valid       = head_beat.valid;
    assign tx_tlp_start   = head_beat.tlp_start;
    assign tx_tlp_end     = head_beat.tlp_end;
    assign tx_dllp_start  = head_beat.dllp_start;
    assign tx_dllp_end    = head_beat.dllp_end;
    assign protocol_valid = link_up;
    assign protocol       = PROTO_PCIE;

    always_ff @(posedge Clk) begin
        if (reset) begin
            state           <= S_RESET;
            state_sts       <= ST_RESET;
            link_up         <= 1'b0;
            link_cfg        <= '0;
            stall_req       <= 1'b0;
            ex_cg_req       <= 1'b0;
            phyinl1         <= 1'b0;
            phyinrecenter   <= 1'b0;
            rxframe_errmask <= 1'b0;
        end else if (state_req == ST_LINKRESET) begin
            state           <= S_LINKRESET;
            state_sts       <= ST_LINKRESET;
            link_up         <= 1'b0;
            stall_req       <= 1'b0;
            ex_cg_req       <= 1'b0;
            phyinl1         <= 1'b0;
            phyinrecenter   <= 1'b0;
            rxframe_errmask <= (state == S_RETRAIN);
        end else begin
            // Mask stays up for one cycle after leaving RETRAIN.
            rxframe_errmask <= (state == S_RETRAIN);
            case (state)
                S_RESET: begin
                    if (state_req == ST_ACTIVE && ltssm_l0) begin
                        state     <= S_ACTIVE;
                        state_sts <= ST_ACTIVE;
                        link_up   <= 1'b1;
                        link_cfg  <= clamp_width(lane_width, MAX_WIDTH_CODE);
                    end
                end
                S_ACTIVE: begin
                    if (ltssm_recovery) begin
                        state           <= S_RETRAIN;
                        state_sts       <= ST_RETRAIN;
                        phyinrecenter   <= 1'b1;
                        rxframe_errmask <= 1'b1;
                    end else if (state_req == ST_L1) begin
                        state     <= S_STALL;
                        stall_req <= 1'b1;
                    end
                end
                S_RETRAIN: begin
                    if (ltssm_l0 && !ltssm_recovery) begin
                        state         <= S_ACTIVE;
                        state_sts     <= ST_ACTIVE;
                        phyinrecenter <= 1'b0;
                        link_up       <= 1'b1;
                        link_cfg      <= clamp_width(lane_width, MAX_WIDTH_CODE);
                    end
                end
                S_STALL: begin
                    // Buffered beats must reach the PHY before entering L1.
                    if (stall_ack && fifo_empty) begin
                        state     <= S_L1;
                        state_sts <= ST_L1;
                        stall_req <= 1'b0;
                        phyinl1   <= 1'b1;
                        ex_cg_req <= 1'b1;
                    end
                end
                S_L1: begin
                    if (ex_cg_req && ex_cg_ack) begin
                        ex_cg_req <= 1'b0;
                    end
                    if (state_req == ST_ACTIVE) begin
                        state           <= S_RETRAIN;
                        state_sts       <= ST_RETRAIN;
                        phyinl1         <= 1'b0;
                        ex_cg_req       <= 1'b0;
                        phyinrecenter   <= 1'b1;
                        rxframe_errmask <= 1'b1;
                    end
                end
                S_LINKRESET: begin
                    state     <= S_RESET;
                    state_sts <= ST_RESET;
                end
                default: begin
                    state     <= S_RESET;
                    state_sts <= ST_RESET;
                end
            endcase
        end
    end

endmodule
